// File: rtl/ft600_tx_buffer_if.sv
// Producer-side and bus-side signals of the FT600 transmit staging FIFO.
// master: the user producer plus the FT600 bus interface. slave: the buffer.
interface ft600_tx_buffer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             enq_valid;
    logic [WIDTH-1:0] enq_data;
    logic             enq_ready;
    logic             usb_deq;
    logic [WIDTH-1:0] usb_data;
    logic             usb_fifo_empty;
    logic [CW-1:0]    count;
    logic             underflow_err;

    modport master (
        output enq_valid, enq_data, usb_deq,
        input  enq_ready, usb_data, usb_fifo_empty, count, underflow_err
    );

    modport slave (
        input  enq_valid, enq_data, usb_deq,
        output enq_ready, usb_data, usb_fifo_empty, count, underflow_err
    );
endinterface

// File: rtl/ft600_tx_buffer.sv
// Transmit staging FIFO for the FT600 bus interface. Words are held back
// (usb_fifo_empty=1) until a full burst is buffered or a partial burst has
// waited FLUSH_CYCLES, then drained first-word-fall-through until empty.
module ft600_tx_buffer #(
    parameter int DEPTH        = 16,
    parameter int WIDTH        = 16,
    parameter int BURST        = 4,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    ft600_tx_buffer_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(FLUSH_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q, count_next;
    logic [TW-1:0]    timer_q, timer_next;
    state_t           state_q, state_next;
    logic             underflow_q;
    logic             do_enq, do_deq;

    // All outputs come from registered state; usb_deq only feeds next-state logic.
    assign bus.enq_ready      = (count_q != CW'(DEPTH));
    assign bus.usb_fifo_empty = (state_q != DRAIN);
    assign bus.usb_data       = mem[rd_ptr];
    assign bus.count          = count_q;
    assign bus.underflow_err  = underflow_q;

    assign do_enq = bus.enq_valid && bus.enq_ready;
    assign do_deq = bus.usb_deq && (state_q == DRAIN);

    // Post-edge occupancy; enq+deq together leaves it unchanged.
    always_comb begin
        count_next = count_q;
        case ({do_enq, do_deq})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    // Burst gating: hold words until BURST are buffered or the flush timer expires.
    always_comb begin
        state_next = state_q;
        timer_next = timer_q;
        case (state_q)
            IDLE: begin
                if (do_enq) begin
                    timer_next = '0;
                    state_next = (count_next >= CW'(BURST)) ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (timer_q != '1)
                    timer_next = timer_q + 1'b1;
                if (count_next >= CW'(BURST) || timer_q == TW'(FLUSH_CYCLES - 1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (count_next == '0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage array; contents need no reset since count gates their use.
    always_ff @(posedge CLK) begin
        if (do_enq)
            mem[wr_ptr] <= bus.enq_data;
    end

    // Pointers, occupancy, FSM, timer and the sticky underflow flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            timer_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_next;
            state_q <= state_next;
            timer_q <= timer_next;
            if (bus.usb_deq && bus.usb_fifo_empty)
                underflow_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ft600_tx_buffer.sv
// Randomised and directed bench for ft600_tx_buffer against a queue-based
// reference: words are released once BURST are held or FLUSH_CYCLES edges
// have passed since the first word arrived in an empty buffer.
module tb_ft600_tx_buffer;
    localparam int DEPTH = 16;
    localparam int WIDTH = 16;
    localparam int BURST = 4;
    localparam int FLUSH = 64;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ft600_tx_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ft600_tx_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BURST(BURST), .FLUSH_CYCLES(FLUSH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference state
    logic [WIDTH-1:0] q[$];
    bit  rel = 0;
    bit  uf  = 0;
    int  cyc = 0;
    int  t0  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge to the reference using the inputs now on the bus.
    task automatic mdl_edge();
        bit enq, deq;
        if (RST) begin
            q.delete();
            rel = 0;
            uf  = 0;
        end else begin
            deq = bus.usb_deq && rel;
            enq = bus.enq_valid && (q.size() < DEPTH);
            if (bus.usb_deq && !rel) uf = 1;
            if (enq && q.size() == 0 && !rel) t0 = cyc;
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(bus.enq_data);
            if (rel && q.size() == 0)
                rel = 0;
            else if (!rel && q.size() > 0 && (q.size() >= BURST || cyc - t0 >= FLUSH))
                rel = 1;
        end
        cyc++;
    endtask

    task automatic chk_all();
        chk("rdy",   32'(bus.enq_ready),      32'(q.size() < DEPTH));
        chk("empty", 32'(bus.usb_fifo_empty), 32'(!rel));
        chk("count", 32'(bus.count),          q.size());
        chk("uf",    32'(bus.underflow_err),  32'(uf));
        if (rel) chk("data", 32'(bus.usb_data), 32'(q[0]));
    endtask

    // One cycle: edge, reference update, then check away from the edge.
    task automatic step();
        @(posedge CLK);
        mdl_edge();
        @(negedge CLK);
        chk_all();
    endtask

    task automatic idle_in();
        bus.enq_valid = 0;
        bus.usb_deq   = 0;
    endtask

    task automatic drain();
        int n = 0;
        idle_in();
        bus.usb_deq = 1;
        while (!bus.usb_fifo_empty && n < 200) begin
            step();
            n++;
        end
        bus.usb_deq = 0;
        chk("drain_to", 32'(bus.usb_fifo_empty), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] burst_w [4];
        int pv, pd;
        burst_w[0] = 16'h1111; burst_w[1] = 16'h2222;
        burst_w[2] = 16'h3333; burst_w[3] = 16'h4444;
        bus.enq_data = '0;
        idle_in();
        RST = 1;
        @(negedge CLK);
        step();
        step();
        RST = 0;

        // idle after reset
        repeat (100) step();
        chk("rst_cnt", 32'(bus.count), 32'd0);

        // full burst release and in-order drain
        bus.enq_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.enq_data = burst_w[i];
            step();
        end
        bus.enq_valid = 0;
        chk("burst_rel", 32'(bus.usb_fifo_empty), 32'd0);
        bus.usb_deq = 1;
        for (int i = 0; i < 4; i++) begin
            chk("burst_data", 32'(bus.usb_data), 32'(burst_w[i]));
            step();
        end
        bus.usb_deq = 0;
        chk("burst_end", 32'(bus.usb_fifo_empty), 32'd1);

        // partial burst flush timeout
        bus.enq_valid = 1;
        bus.enq_data  = 16'hBEEF;
        step();
        bus.enq_valid = 0;
        for (int i = 1; i < FLUSH; i++) begin
            step();
            chk("flush_hold", 32'(bus.usb_fifo_empty), 32'd1);
        end
        step();
        chk("flush_rel", 32'(bus.usb_fifo_empty), 32'd0);
        chk("flush_data", 32'(bus.usb_data), 32'h0000BEEF);
        bus.usb_deq = 1;
        step();
        bus.usb_deq = 0;
        chk("flush_end", 32'(bus.usb_fifo_empty), 32'd1);

        // fill past capacity, then drain across pointer wrap
        bus.enq_valid = 1;
        for (int i = 0; i < 17; i++) begin
            bus.enq_data = 16'h0100 + 16'(i);
            step();
            if (i == 15) chk("full_rdy", 32'(bus.enq_ready), 32'd0);
        end
        chk("full_cnt", 32'(bus.count), 32'd16);
        bus.usb_deq = 1;
        step();
        bus.usb_deq = 0;
        chk("free_rdy", 32'(bus.enq_ready), 32'd1);
        step();
        bus.enq_valid = 0;
        chk("refill_cnt", 32'(bus.count), 32'd16);
        bus.usb_deq = 1;
        for (int i = 1; i < 17; i++) begin
            chk("wrap_data", 32'(bus.usb_data), 32'h0100 + 32'(i));
            step();
        end
        bus.usb_deq = 0;
        chk("wrap_end", 32'(bus.count), 32'd0);

        // concurrent enqueue and dequeue in DRAIN at count=2
        bus.enq_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.enq_data = 16'($urandom);
            step();
        end
        bus.enq_valid = 0;
        bus.usb_deq = 1;
        step();
        step();
        bus.enq_valid = 1;
        for (int i = 0; i < 10; i++) begin
            bus.enq_data = 16'($urandom);
            step();
            chk("conc_cnt", 32'(bus.count), 32'd2);
        end
        drain();

        // underflow is sticky; reset mid-fill clears everything
        bus.usb_deq = 1;
        step();
        bus.usb_deq = 0;
        chk("uf_set", 32'(bus.underflow_err), 32'd1);
        repeat (5) step();
        chk("uf_hold", 32'(bus.underflow_err), 32'd1);
        bus.enq_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.enq_data = 16'($urandom);
            step();
        end
        bus.enq_valid = 0;
        RST = 1;
        step();
        RST = 0;
        chk("rst_cnt2",   32'(bus.count),          32'd0);
        chk("rst_empty2", 32'(bus.usb_fifo_empty), 32'd1);
        chk("rst_uf2",    32'(bus.underflow_err),  32'd0);

        // randomised traffic with varying pressure and rare resets
        pv = 50;
        pd = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pv = int'($urandom_range(5, 95));
                pd = int'($urandom_range(5, 95));
            end
            bus.enq_valid = ($urandom_range(0, 99) < pv);
            bus.enq_data  = 16'($urandom);
            bus.usb_deq   = ($urandom_range(0, 99) < pd);
            RST           = ($urandom_range(0, 499) == 0);
            step();
        end
        RST = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
